// File: rtl/lfsr_range_rand.sv
// rtl/lfsr_range_rand.sv - Galois LFSR random source with bounded rejection sampling into [0, RANGE-1]
module lfsr_range_rand #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] TAPS      = 32'h000000B7,
    parameter logic [31:0] SEED      = 32'd300,
    parameter int          OUT_W     = 7,
    parameter int          RANGE     = 100,
    parameter int          MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             rand_valid,
    output logic [OUT_W-1:0] rand_out,
    output logic             rand_fallback
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    // Bit 0 of the feedback is the rotated-in MSB, so only taps above bit 0 are xored.
    localparam logic [WIDTH-1:0] TAP_MASK  = WIDTH'(TAPS) & ~WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
    localparam logic [OUT_W:0]   RANGE_X   = (OUT_W+1)'(RANGE);
    localparam logic [OUT_W-1:0] RANGE_N   = OUT_W'(RANGE);
    localparam logic [TW-1:0]    LAST_TRY  = TW'(MAX_TRIES - 1);

    typedef enum logic {
        S_IDLE,
        S_DRAW
    } fsm_t;

    fsm_t             r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [TW-1:0]    r_tries;
    logic             r_busy;
    logic             r_valid;
    logic [OUT_W-1:0] r_out;
    logic             r_fallback;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_seed;
    logic [OUT_W-1:0] w_cand;
    logic             w_accept;
    logic             w_last;

    always_comb begin
        w_step   = {r_state[WIDTH-2:0], r_state[WIDTH-1]} ^ (TAP_MASK & {WIDTH{r_state[WIDTH-1]}});
        w_seed   = (seed_in == '0) ? SEED_W : seed_in;
        w_cand   = r_state[OUT_W-1:0];
        w_accept = ({1'b0, w_cand} < RANGE_X);
        w_last   = (r_tries == LAST_TRY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= S_IDLE;
            r_state    <= SEED_W;
            r_tries    <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_fallback <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (seed_load) begin
                        r_state <= w_seed;
                    end else if (en) begin
                        r_state <= w_step;
                    end
                    if (req) begin
                        r_fsm   <= S_DRAW;
                        r_tries <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAW: begin
                    // A seed load stalls the draw: no candidate is judged this cycle.
                    if (seed_load) begin
                        r_state <= w_seed;
                    end else begin
                        r_state <= w_step;
                        if (w_accept) begin
                            r_out      <= w_cand;
                            r_fallback <= 1'b0;
                            r_valid    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_fsm      <= S_IDLE;
                        end else if (w_last) begin
                            r_out      <= w_cand - RANGE_N;
                            r_fallback <= 1'b1;
                            r_valid    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_fsm      <= S_IDLE;
                        end else begin
                            r_tries <= r_tries + TW'(1);
                        end
                    end
                end
                default: begin
                    r_fsm  <= S_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign rand_valid    = r_valid;
    assign rand_out      = r_out;
    assign rand_fallback = r_fallback;

endmodule

// File: tb/tb_lfsr_range_rand.sv
// tb/tb_lfsr_range_rand.sv - directed checks of lfsr_range_rand against hand-computed draws
module tb_lfsr_range_rand;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = '0;
    logic        req = 1'b0;

    logic        busy, rand_valid, rand_fallback;
    logic [6:0]  rand_out;
    logic        busy2, rand_valid2, rand_fallback2;
    logic [6:0]  rand_out2;

    int checks = 0;
    int errors = 0;
    int nv;

    always #5 clk = ~clk;

    lfsr_range_rand dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .busy(busy), .rand_valid(rand_valid), .rand_out(rand_out),
        .rand_fallback(rand_fallback)
    );

    lfsr_range_rand #(.MAX_TRIES(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .busy(busy2), .rand_valid(rand_valid2), .rand_out(rand_out2),
        .rand_fallback(rand_fallback2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", rand_valid, 0);
        chk("reset_out", rand_out, 0);
        chk("reset_fb", rand_fallback, 0);

        // Seed 300 -> first candidate 44, accepted immediately
        pulse_req();
        chk("t1_busy", busy, 1);
        chk("t1_valid_early", rand_valid, 0);
        tick();
        chk("t1_valid", rand_valid, 1);
        chk("t1_out", rand_out, 44);
        chk("t1_fb", rand_fallback, 0);
        chk("t1_busy_fall", busy, 0);
        tick();
        chk("t1_valid_pulse", rand_valid, 0);
        chk("t1_out_hold", rand_out, 44);

        load_seed(32'd1);
        pulse_req();
        tick();
        chk("t2_valid", rand_valid, 1);
        chk("t2_out", rand_out, 1);

        // Seed 0x7F: candidates 127,126,124,120,112,96; MAX_TRIES=2 instance falls back to 26
        tick();
        load_seed(32'h7F);
        pulse_req();
        chk("t3_busy0", busy, 1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) begin
                chk("t3_busy", busy, 1);
                chk("t3_novalid", rand_valid, 0);
            end else begin
                chk("t3_valid", rand_valid, 1);
                chk("t3_out", rand_out, 96);
                chk("t3_fb", rand_fallback, 0);
                chk("t3_busy_fall", busy, 0);
            end
            if (i == 1) chk("t3m2_novalid", rand_valid2, 0);
            if (i == 2) begin
                chk("t3m2_valid", rand_valid2, 1);
                chk("t3m2_out", rand_out2, 26);
                chk("t3m2_fb", rand_fallback2, 1);
            end
        end
        tick();

        // 0x80000000 stepped once gives TAPS = 0xB7 -> candidate 55
        load_seed(32'h8000_0000);
        en = 1'b1;
        tick();
        en = 1'b0;
        pulse_req();
        tick();
        chk("t4_valid", rand_valid, 1);
        chk("t4_out", rand_out, 55);

        // Zero seed substitutes SEED
        tick();
        load_seed(32'd0);
        pulse_req();
        tick();
        chk("t5_valid", rand_valid, 1);
        chk("t5_out", rand_out, 44);

        // Seed load mid-draw stalls one cycle then draws from the new state
        tick();
        load_seed(32'h7F);
        pulse_req();
        tick();
        seed_load = 1'b1;
        seed_in   = 32'd1;
        tick();
        seed_load = 1'b0;
        chk("t6_stall_busy", busy, 1);
        chk("t6_stall_novalid", rand_valid, 0);
        tick();
        chk("t6_valid", rand_valid, 1);
        chk("t6_out", rand_out, 1);
        chk("t6_fb", rand_fallback, 0);

        // req while busy is ignored
        tick();
        load_seed(32'h7F);
        pulse_req();
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (rand_valid) nv++;
            tick();
        end
        chk("t7_single_valid", nv, 1);
        chk("t7_out", rand_out, 96);

        // Reset mid-draw aborts with no result
        load_seed(32'h7F);
        pulse_req();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t8_busy", busy, 0);
        chk("t8_valid", rand_valid, 0);
        chk("t8_out", rand_out, 0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rand_valid) nv++;
        end
        chk("t8_no_valid", nv, 0);
        pulse_req();
        tick();
        chk("t8_seed_valid", rand_valid, 1);
        chk("t8_seed_out", rand_out, 44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
